send_queue_writer: RTL and testbench
====================================

// Module: send_queue_writer
// PURPOSE
//  Producer side of the UART transmit ring buffer. Accepts byte or 32-bit word
//  output requests from the core, serialises words MSB-first into a 2^AW-entry
//  byte ring, and publishes the tail pointer queue_t.
//  The UART output manager consumes entries from head queue_s, which it supplies.
//  Sits between the core's OUT path and the output manager.
// PARAMETERS
//  AW     9    ring address width; depth = 2**AW (512 at default)
// PORTS
//  CLK         in   1       system clock, all logic on posedge
//  RST_N       in   1       synchronous active-low reset
//  WR_VALID    in   1       core request valid
//  WR_READY    out  1       request accepted when WR_VALID && WR_READY at posedge
//  WR_WORD     in   1       1: push WR_DATA[31:0] as 4 bytes; 0: push WR_DATA[7:0]
//  WR_DATA     in   32      request payload
//  queue_s     in   AW      head pointer from output manager (next byte to send)
//  send_queue  out  8x2^AW  ring storage, read by output manager
//  queue_t     out  AW      tail pointer (next free slot)
//  FULL        out  1       (queue_t+1) mod 2^AW == queue_s
//  OCCUPANCY   out  AW      (queue_t - queue_s) mod 2^AW, max 2^AW-1
// BEHAVIOUR
//  Reset (RST_N=0 at posedge): queue_t=0, state=IDLE, shift reg/count cleared,
//   WR_READY=0 while RST_N low; send_queue contents not reset. The downstream
//   manager's head must be reset in the same cycle, so that head = tail = 0.
//  FSM IDLE/PUSH. WR_READY = RST_N && state==IDLE (no combinational path from WR_*).
//  IDLE: on accept, latch payload into 32b shift reg. Set remaining = 4 (word) or 1 (byte).
//   Byte payload occupies bits [31:24]. Go to PUSH.
//  PUSH: each posedge with !FULL: send_queue[queue_t] <= shreg[31:24];
//   queue_t <= queue_t+1 (wraps 2^AW-1 -> 0); shreg <<= 8; remaining--.
//   After the last byte is written, go to IDLE (WR_READY high next cycle).
//  FULL in PUSH: hold everything; no write, no pointer move; resume once queue_s advances.
//  Latency: accept at edge N -> first byte visible at edge N+1 (if not full).
//   Word -> bytes at N+1..N+4; throughput 1 request / (bytes+1) cycles.
//  One slot is always kept empty: empty = (queue_t==queue_s), usable capacity 2^AW-1.
//  Pointer arithmetic is AW-bit modular; OCCUPANCY/FULL are combinational from queue_t, queue_s.
//  queue_s moving in the same cycle as a write is legal: FULL is evaluated on the pre-edge values.
//   The freed slot is usable next cycle.
//  Reset mid-PUSH: pending bytes discarded, queue_t=0, IDLE.
//  WR_VALID while WR_READY=0 is ignored; the core holds the request until accepted.
// CONFIGURATION
//  SEND_QUEUE_HIGHWATER_EN defined: adds output HIGHWATER [AW-1:0], reset 0.
//   Each cycle HIGHWATER <= max(HIGHWATER, OCCUPANCY); never decreases until reset.
//  Undefined: no HIGHWATER port or register; all other behaviour identical.
// TESTING
//  1 reset, queue_s=0; byte 0x41 accepted at edge N -> edge N+1: send_queue[0]=0x41,
//    queue_t=1, OCCUPANCY=1; WR_READY=1 at N+2.
//  2 word 0xDEADBEEF -> send_queue[0..3]=DE,AD,BE,EF on 4 consecutive edges; queue_t=4;
//    WR_READY=0 throughout PUSH.
//  3 queue_s held 0, 511 bytes -> queue_t=511, FULL=1; a further word stalls in PUSH
//    with queue_t=511; set queue_s=2 -> 2 bytes written, FULL again; queue_s=5 -> completes.
//  4 wrap: queue_s=queue_t=510, word 0x01020304 -> [510]=01,[511]=02,[0]=03,[1]=04;
//    queue_t=2, OCCUPANCY=4.
//  5 RST_N low after 2 bytes of a word -> queue_t=0, IDLE; WR_READY=0 while low,
//    1 on the first cycle after release.
//  6 SEND_QUEUE_HIGHWATER_EN: fill to 10, drain to 3 -> HIGHWATER=10; reset -> 0.

Source files
------------

// File: rtl/send_queue_writer.sv
// rtl/send_queue_writer.sv - UART transmit ring producer: byte/word requests serialised MSB-first into a 2^AW byte ring
// Optional build macro SEND_QUEUE_HIGHWATER_EN adds a sticky peak-occupancy output HIGHWATER.
module send_queue_writer #(
  parameter int AW = 9
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     WR_VALID,
  output logic                     WR_READY,
  input  logic                     WR_WORD,
  input  logic [31:0]              WR_DATA,
  input  logic [AW-1:0]            queue_s,
  output logic [8*(2**AW)-1:0]     send_queue,
  output logic [AW-1:0]            queue_t,
  output logic                     FULL,
  output logic [AW-1:0]            OCCUPANCY
`ifdef SEND_QUEUE_HIGHWATER_EN
  ,
  output logic [AW-1:0]            HIGHWATER
`endif
);

  localparam int DEPTH = 2**AW;

  typedef enum logic {
    IDLE = 1'b0,
    PUSH = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] shreg;
  logic [2:0]  remaining;
  logic [7:0]  ring [DEPTH];
  logic        do_write;

  // One slot stays empty so that head == tail always means empty.
  assign FULL      = (queue_t + {{(AW-1){1'b0}}, 1'b1}) == queue_s;
  assign OCCUPANCY = queue_t - queue_s;
  assign WR_READY  = RST_N && (state == IDLE);
  assign do_write  = RST_N && (state == PUSH) && !FULL;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      queue_t   <= '0;
      shreg     <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (WR_VALID) begin
            shreg     <= WR_WORD ? WR_DATA : {WR_DATA[7:0], 24'h0};
            remaining <= WR_WORD ? 3'd4 : 3'd1;
            state     <= PUSH;
          end
        end
        PUSH: begin
          if (!FULL) begin
            queue_t   <= queue_t + {{(AW-1){1'b0}}, 1'b1};
            shreg     <= {shreg[23:0], 8'h0};
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Ring contents are deliberately not reset.
  always_ff @(posedge CLK) begin
    if (do_write) ring[queue_t] <= shreg[31:24];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign send_queue[8*i +: 8] = ring[i];
  end

`ifdef SEND_QUEUE_HIGHWATER_EN
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      HIGHWATER <= '0;
    end else if (OCCUPANCY > HIGHWATER) begin
      HIGHWATER <= OCCUPANCY;
    end
  end
`endif

endmodule

// File: tb/tb_send_queue_writer.sv
// tb/tb_send_queue_writer.sv - randomized and directed bench for send_queue_writer against a queue-based reference model
module tb_send_queue_writer;

  localparam int AW    = 9;
  localparam int DEPTH = 2**AW;
  localparam int MASK  = DEPTH - 1;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 WR_VALID = 1'b0;
  logic                 WR_READY;
  logic                 WR_WORD = 1'b0;
  logic [31:0]          WR_DATA = '0;
  logic [AW-1:0]        queue_s = '0;
  logic [8*DEPTH-1:0]   send_queue;
  logic [AW-1:0]        queue_t;
  logic                 FULL;
  logic [AW-1:0]        OCCUPANCY;
`ifdef SEND_QUEUE_HIGHWATER_EN
  logic [AW-1:0]        HIGHWATER;
`endif

  send_queue_writer #(.AW(AW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .WR_WORD   (WR_WORD),
    .WR_DATA   (WR_DATA),
    .queue_s   (queue_s),
    .send_queue(send_queue),
    .queue_t   (queue_t),
    .FULL      (FULL),
    .OCCUPANCY (OCCUPANCY)
`ifdef SEND_QUEUE_HIGHWATER_EN
    ,
    .HIGHWATER (HIGHWATER)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // Reference model: ring as an array, outstanding request bytes as a queue.
  logic [7:0] ref_mem [DEPTH];
  bit         ref_known [DEPTH];
  int         ref_t = 0;
  int         ref_hw = 0;
  logic [7:0] pend [$];
  bit         ref_accept = 1'b0;

  function automatic int occ_of(int t, int s);
    return (t - s) & MASK;
  endfunction

  always @(posedge CLK) begin
    int  qs;
    int  occ_pre;
    bit  full_pre;
    qs = int'(queue_s);
    occ_pre = occ_of(ref_t, qs);
    full_pre = (((ref_t + 1) & MASK) == qs);
    ref_accept = 1'b0;
    if (!RST_N) begin
      ref_t = 0;
      ref_hw = 0;
      pend.delete();
    end else begin
      if (occ_pre > ref_hw) ref_hw = occ_pre;
      if (pend.size() > 0) begin
        if (!full_pre) begin
          ref_mem[ref_t] = pend.pop_front();
          ref_known[ref_t] = 1'b1;
          ref_t = (ref_t + 1) & MASK;
        end
      end else if (WR_VALID) begin
        ref_accept = 1'b1;
        if (WR_WORD) begin
          for (int b = 3; b >= 0; b--) pend.push_back(WR_DATA[8*b +: 8]);
        end else begin
          pend.push_back(WR_DATA[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sq_byte(int i);
    return int'(send_queue[8*i +: 8]);
  endfunction

  // Single compare process against the model, sampled on the falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      int bad_idx;
      bad_idx = -1;
      chk("model_ready", int'(WR_READY), int'(RST_N && pend.size() == 0));
      chk("model_queue_t", int'(queue_t), ref_t);
      chk("model_full", int'(FULL), int'(((ref_t + 1) & MASK) == int'(queue_s)));
      chk("model_occ", int'(OCCUPANCY), occ_of(ref_t, int'(queue_s)));
`ifdef SEND_QUEUE_HIGHWATER_EN
      chk("model_highwater", int'(HIGHWATER), ref_hw);
`endif
      for (int i = 0; i < DEPTH; i++) begin
        if (ref_known[i] && bad_idx < 0 && sq_byte(i) != int'(ref_mem[i])) bad_idx = i;
      end
      if (bad_idx >= 0) chk("model_ring", sq_byte(bad_idx), int'(ref_mem[bad_idx]));
      else chk("model_ring", 0, 0);
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    WR_VALID = 1'b0;
    queue_s = '0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  // Present one request for exactly one edge; caller ensures WR_READY is high.
  task automatic request(input bit word, input logic [31:0] data);
    WR_VALID = 1'b1;
    WR_WORD = word;
    WR_DATA = data;
    step();
    WR_VALID = 1'b0;
  endtask

  task automatic push_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      request(1'b0, 32'(i));
      step();
    end
  endtask

  initial begin
    logic [31:0] wd;
    int occ;
    int slow;

    do_reset();
    chk_en = 1'b1;

    // 1: single byte
    chk("reset_queue_t", int'(queue_t), 0);
    chk("reset_occ", int'(OCCUPANCY), 0);
    request(1'b0, 32'h0000_0041);
    chk("t1_ready_low", int'(WR_READY), 0);
    step();
    chk("t1_byte0", sq_byte(0), 'h41);
    chk("t1_queue_t", int'(queue_t), 1);
    chk("t1_occ", int'(OCCUPANCY), 1);
    chk("t1_ready_back", int'(WR_READY), 1);

    // 2: word MSB first
    do_reset();
    wd = 32'hDEAD_BEEF;
    request(1'b1, wd);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t2_byte", sq_byte(k - 1), int'(wd[8*(4-k) +: 8]));
      chk("t2_queue_t", int'(queue_t), k);
      chk("t2_ready", int'(WR_READY), int'(k == 4));
    end

    // 3: fill, stall on FULL, resume as head advances
    do_reset();
    push_bytes(511);
    chk("t3_queue_t", int'(queue_t), 511);
    chk("t3_full", int'(FULL), 1);
    request(1'b1, 32'hA1B2_C3D4);
    step();
    step();
    chk("t3_stall_qt", int'(queue_t), 511);
    chk("t3_stall_ready", int'(WR_READY), 0);
    queue_s = 9'd2;
    step();
    step();
    step();
    chk("t3_part_qt", int'(queue_t), 1);
    chk("t3_part_full", int'(FULL), 1);
    chk("t3_b511", sq_byte(511), 'hA1);
    chk("t3_b0", sq_byte(0), 'hB2);
    queue_s = 9'd5;
    step();
    step();
    chk("t3_b1", sq_byte(1), 'hC3);
    chk("t3_b2", sq_byte(2), 'hD4);
    chk("t3_done_qt", int'(queue_t), 3);
    chk("t3_done_ready", int'(WR_READY), 1);

    // 4: wrap across the top of the ring
    do_reset();
    push_bytes(510);
    queue_s = 9'd510;
    request(1'b1, 32'h0102_0304);
    for (int k = 0; k < 4; k++) step();
    chk("t4_b510", sq_byte(510), 'h01);
    chk("t4_b511", sq_byte(511), 'h02);
    chk("t4_b0", sq_byte(0), 'h03);
    chk("t4_b1", sq_byte(1), 'h04);
    chk("t4_queue_t", int'(queue_t), 2);
    chk("t4_occ", int'(OCCUPANCY), 4);

    // 5: reset in the middle of a word
    do_reset();
    request(1'b1, 32'h1122_3344);
    step();
    step();
    chk("t5_mid_qt", int'(queue_t), 2);
    RST_N = 1'b0;
    queue_s = '0;
    #1;
    chk("t5_ready_in_rst", int'(WR_READY), 0);
    step();
    chk("t5_rst_qt", int'(queue_t), 0);
    chk("t5_ready_in_rst2", int'(WR_READY), 0);
    RST_N = 1'b1;
    #1;
    chk("t5_ready_release", int'(WR_READY), 1);
    step();
    chk("t5_idle_qt", int'(queue_t), 0);

`ifdef SEND_QUEUE_HIGHWATER_EN
    // 6: sticky peak occupancy
    do_reset();
    push_bytes(10);
    queue_s = 9'd7;
    step();
    step();
    chk("t6_occ", int'(OCCUPANCY), 3);
    chk("t6_highwater", int'(HIGHWATER), 10);
    do_reset();
    step();
    chk("t6_hw_reset", int'(HIGHWATER), 0);
`endif

    // Randomized traffic with a variable-speed consumer and occasional resets.
    do_reset();
    slow = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      if (!RST_N) begin
        RST_N = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        RST_N = 1'b0;
        WR_VALID = 1'b0;
        queue_s = '0;
        continue;
      end
      if (cyc % 600 == 0) slow = int'($urandom_range(0, 1));
      if (ref_accept) WR_VALID = 1'b0;
      if (!WR_VALID && $urandom_range(0, 2) != 0) begin
        WR_VALID = 1'b1;
        WR_WORD = 1'($urandom_range(0, 1));
        WR_DATA = $urandom;
      end
      occ = occ_of(ref_t, int'(queue_s));
      if (occ > 0 && $urandom_range(0, slow ? 15 : 2) == 0) begin
        queue_s = AW'((int'(queue_s) + int'($urandom_range(1, (occ < 3) ? occ : 3))) & MASK);
      end
    end

    WR_VALID = 1'b0;
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
